adda_bram_arbiter: RTL and testbench
====================================

# adda_bram_arbiter

Two-requester arbiter sharing the data-side port B of the local-memory block RAM between the ADC capture engine (master 0) and the DAC playback engine (master 1). It sits between the two converter engines and the BRAM port B pins. It issues at most one single-beat, 32-bit access per cycle and checks each request against the BRAM address window. It returns read data with a fixed latency.

## Interface
- C_BASEADDR, 32'h0000_0000, byte base address of the BRAM window
- C_MEMSIZE, 'h10000, window size in bytes (power of two)
- C_PORT_DWIDTH, 32, data width (fixed at 32)
- C_NUM_WE, 4, byte write enables
- Clk  in  1  sole clock; all logic on rising edge
- Rst_N  in  1  asynchronous, active-low reset
- M0_Req / M1_Req  in  1  request; held with fields stable until Ack
- M0_Wr / M1_Wr  in  1  1 = write, 0 = read
- M0_Addr / M1_Addr  in  [0:31]  byte address, word aligned (bits 30:31 ignored)
- M0_WData / M1_WData  in  [0:31]  write data
- M0_BE / M1_BE  in  [0:3]  byte enables for writes
- M0_Ack / M1_Ack  out  1  one-cycle request-accepted pulse
- M0_Err / M1_Err  out  1  qualifies Ack: address outside window, no access made
- M0_RValid / M1_RValid  out  1  one-cycle read-data-valid pulse
- M_RData  out  [0:31]  read data, shared, qualified by RValid
- BRAM_EN_B  out  1;  BRAM_WEN_B  out  [0:3];  BRAM_Addr_B  out  [0:31];  BRAM_Dout_B  out  [0:31] (write data into BRAM);  BRAM_Din_B  in  [0:31] (read data from BRAM)

## Operation
- FSM states: IDLE, ISSUE0, ISSUE1. A state is entered at the edge where the grant is decided and is held for exactly one cycle. From ISSUEx the FSM returns to IDLE or goes to the other ISSUE state.
- Eligibility: Mx_Req=1 and master x is not in its ISSUE cycle, so a held Req is never granted twice.
- Arbitration is round-robin. A last-grant flag (reset 1) gives priority to the master not granted last. A sole eligible master always wins.
- In ISSUEx with the address in range, the block drives:
  - BRAM_EN_B=1
  - BRAM_Addr_B = Mx_Addr with bits 30:31 forced to 0
  - BRAM_WEN_B = Mx_BE when writing, 0 when reading
  - BRAM_Dout_B = Mx_WData
  - Mx_Ack=1
- Range check: in range when (Addr − C_BASEADDR) < C_MEMSIZE, using unsigned 32-bit arithmetic so addresses below the base wrap and fail. Out of range: Ack=1, Err=1, EN=0, WEN=0, no RValid.
- A read issued in cycle t raises Mx_RValid in t+1. M_RData = BRAM_Din_B, passed through without a register.
- A write of BE=0000 is legal: it is acked and EN=1 with WEN=0.

## Timing
- Reset values: all outputs 0, FSM=IDLE, last-grant=1. Any in-flight RValid is dropped.
- Grant decided from inputs sampled at edge n; ISSUE, Ack and BRAM strobes are registered and valid in cycle n+1. Read latency from Req sampled to RValid is 2 cycles.
- Sustained throughput: each master gets one access per 2 cycles. With both masters requesting continuously, accesses alternate 0,1,0,1 and the port is busy every cycle.
- Simultaneous first requests after reset: master 0 wins, because last-grant=1.
- A master dropping Req before Ack is a protocol violation; behaviour is unspecified.
- Reset asserted mid-access clears the strobes asynchronously. The BRAM write completes only if EN/WEN were already sampled at the preceding edge.

## Configuration
- ADDA_ARB_FIXED_PRIO_EN defined: master 0 has fixed priority and wins every contested cycle. Master 1 is served only when master 0 is not eligible, including master 0's ISSUE cycle, so master 1 still gets at least every second cycle under contention. The last-grant flag is not implemented.
- Not defined: round-robin as described in Operation.

## Test plan
- Single read: reset, preload word 0x0000_0010 = 0xDEAD_BEEF, M0 reads 0x10 → Ack at cycle 1, BRAM_Addr_B=0x10, RValid at cycle 2 with M_RData=0xDEAD_BEEF.
- Byte write: M1 writes 0x1234_5678 with BE=0011 to 0x20 over 0xFFFF_FFFF → readback 0xFFFF_5678.
- Contention: both masters request continuously for 8 accesses → grants 0,1,0,1,… with EN=1 every cycle. With ADDA_ARB_FIXED_PRIO_EN the pattern is the same, and M0 wins whenever M1 is idle.
- Out of range: M0 reads 0x0001_0000 with C_MEMSIZE='h10000 → Ack=1, Err=1, EN=0, no RValid. With C_BASEADDR=0x100, address 0x0FC is also Err (wrap).
- Reset mid-read: assert Rst_N=0 in the issue cycle → all outputs 0 at once, no RValid after release, first contested grant goes to M0.

Source files
------------

// File: rtl/adda_bram_arbiter_if.sv
// Request/ack/read-data bundle for both converter engines plus the BRAM port B pins.
// The slave modport is the arbiter's view; master is the engines/BRAM side.
interface adda_bram_arbiter_if;
  logic        m0_req;
  logic        m0_wr;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_be;
  logic        m0_ack;
  logic        m0_err;
  logic        m0_rvalid;

  logic        m1_req;
  logic        m1_wr;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_be;
  logic        m1_ack;
  logic        m1_err;
  logic        m1_rvalid;

  logic [31:0] m_rdata;

  logic        bram_en_b;
  logic [3:0]  bram_wen_b;
  logic [31:0] bram_addr_b;
  logic [31:0] bram_dout_b;
  logic [31:0] bram_din_b;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata, m0_be,
    input  m1_req, m1_wr, m1_addr, m1_wdata, m1_be,
    input  bram_din_b,
    output m0_ack, m0_err, m0_rvalid,
    output m1_ack, m1_err, m1_rvalid,
    output m_rdata,
    output bram_en_b, bram_wen_b, bram_addr_b, bram_dout_b
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata, m0_be,
    output m1_req, m1_wr, m1_addr, m1_wdata, m1_be,
    output bram_din_b,
    input  m0_ack, m0_err, m0_rvalid,
    input  m1_ack, m1_err, m1_rvalid,
    input  m_rdata,
    input  bram_en_b, bram_wen_b, bram_addr_b, bram_dout_b
  );
endinterface

// File: rtl/adda_bram_arbiter.sv
// Round-robin arbiter for BRAM port B between ADC (m0) and DAC (m1) engines; reads return 2 cycles after Req.
// Define ADDA_ARB_FIXED_PRIO_EN to give master 0 fixed priority instead of round-robin.
module adda_bram_arbiter #(
  parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
  parameter logic [31:0] C_MEMSIZE     = 32'h0001_0000,
  parameter int          C_PORT_DWIDTH = 32,
  parameter int          C_NUM_WE      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  adda_bram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE0 = 2'd1,
    ISSUE1 = 2'd2
  } state_t;

  state_t                     state;
  logic                       elig0;
  logic                       elig1;
  logic                       grant0;
  logic                       grant1;
  logic                       grant_any;
  logic                       sel_wr;
  logic [31:0]                sel_addr;
  logic [C_PORT_DWIDTH-1:0]   sel_wdata;
  logic [C_NUM_WE-1:0]        sel_be;
  logic [31:0]                offset;
  logic                       in_range;
  logic                       rd_pend0;
  logic                       rd_pend1;

  // A master sitting in its own issue cycle still holds Req; masking it here
  // prevents granting the same request twice.
  assign elig0 = bus.m0_req && (state != ISSUE0);
  assign elig1 = bus.m1_req && (state != ISSUE1);

`ifdef ADDA_ARB_FIXED_PRIO_EN
  assign grant0 = elig0;
  assign grant1 = elig1 && !elig0;
`else
  logic last_grant;  // 1: master 1 was granted last, so master 0 wins a tie

  assign grant0 = elig0 && (!elig1 || last_grant);
  assign grant1 = elig1 && (!elig0 || !last_grant);
`endif

  assign grant_any = grant0 || grant1;

  assign sel_wr    = grant1 ? bus.m1_wr    : bus.m0_wr;
  assign sel_addr  = grant1 ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = grant1 ? bus.m1_wdata : bus.m0_wdata;
  assign sel_be    = grant1 ? bus.m1_be    : bus.m0_be;

  // Unsigned wrap makes addresses below the base land far above the window.
  assign offset   = sel_addr - C_BASEADDR;
  assign in_range = offset < C_MEMSIZE;

  // BRAM port B has a registered output, so read data lines up with RValid.
  assign bus.m_rdata = bus.bram_din_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
`ifndef ADDA_ARB_FIXED_PRIO_EN
      last_grant      <= 1'b1;
`endif
      bus.m0_ack      <= 1'b0;
      bus.m1_ack      <= 1'b0;
      bus.m0_err      <= 1'b0;
      bus.m1_err      <= 1'b0;
      bus.m0_rvalid   <= 1'b0;
      bus.m1_rvalid   <= 1'b0;
      bus.bram_en_b   <= 1'b0;
      bus.bram_wen_b  <= '0;
      bus.bram_addr_b <= '0;
      bus.bram_dout_b <= '0;
      rd_pend0        <= 1'b0;
      rd_pend1        <= 1'b0;
    end else begin
      if (grant0) begin
        state <= ISSUE0;
      end else if (grant1) begin
        state <= ISSUE1;
      end else begin
        state <= IDLE;
      end

`ifndef ADDA_ARB_FIXED_PRIO_EN
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
`endif

      bus.m0_ack      <= grant0;
      bus.m1_ack      <= grant1;
      bus.m0_err      <= grant0 && !in_range;
      bus.m1_err      <= grant1 && !in_range;

      bus.bram_en_b   <= grant_any && in_range;
      bus.bram_wen_b  <= (grant_any && in_range && sel_wr) ? sel_be : '0;
      bus.bram_addr_b <= grant_any ? {sel_addr[31:2], 2'b00} : '0;
      bus.bram_dout_b <= grant_any ? sel_wdata : '0;

      rd_pend0        <= grant0 && in_range && !sel_wr;
      rd_pend1        <= grant1 && in_range && !sel_wr;
      bus.m0_rvalid   <= rd_pend0;
      bus.m1_rvalid   <= rd_pend1;
    end
  end

endmodule

// File: tb/tb_adda_bram_arbiter.sv
// Directed bench for adda_bram_arbiter with a registered-output BRAM model on port B.
module tb_adda_bram_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  adda_bram_arbiter_if bif ();
  adda_bram_arbiter_if bif2 ();

  adda_bram_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  adda_bram_arbiter #(
    .C_BASEADDR (32'h0000_0100),
    .C_MEMSIZE  (32'h0001_0000)
  ) dut_base (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif2)
  );

`ifdef ADDA_ARB_FIXED_PRIO_EN
  localparam bit ROUND_ROBIN = 1'b0;
`else
  localparam bit ROUND_ROBIN = 1'b1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM port B model: read-first, one-cycle registered output
  logic [31:0] mem [0:63];
  logic [31:0] bram_q;
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_dat;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_dat;
    end else if (bif.bram_en_b) begin
      bram_q <= mem[bif.bram_addr_b[7:2]];
      for (int b = 0; b < 4; b++) begin
        if (bif.bram_wen_b[b]) begin
          mem[bif.bram_addr_b[7:2]][8*b +: 8] <= bif.bram_dout_b[8*b +: 8];
        end
      end
    end
  end

  assign bif.bram_din_b  = bram_q;
  assign bif2.bram_din_b = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    bif.m0_req   = r;
    bif.m0_wr    = w;
    bif.m0_addr  = a;
    bif.m0_wdata = d;
    bif.m0_be    = be;
  endtask

  task automatic req1(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    bif.m1_req   = r;
    bif.m1_wr    = w;
    bif.m1_addr  = a;
    bif.m1_wdata = d;
    bif.m1_be    = be;
  endtask

  task automatic req_b2(input logic r, input logic [31:0] a);
    bif2.m0_req   = r;
    bif2.m0_wr    = 1'b0;
    bif2.m0_addr  = a;
    bif2.m0_wdata = 32'h0;
    bif2.m0_be    = 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_rd;
    n_cmp  = 0;
    n_mis  = 0;
    rst_n  = 1'b0;
    pre_we = 1'b0;
    pre_idx = '0;
    pre_dat = '0;
    req0(0, 0, 0, 0, 0);
    req1(0, 0, 0, 0, 0);
    req_b2(0, 0);
    bif2.m1_req = 1'b0; bif2.m1_wr = 1'b0; bif2.m1_addr = '0;
    bif2.m1_wdata = '0; bif2.m1_be = '0;
    #1;
    check("rst_ack0", {31'b0, bif.m0_ack}, 0);
    check("rst_ack1", {31'b0, bif.m1_ack}, 0);
    check("rst_en",   {31'b0, bif.bram_en_b}, 0);
    check("rst_wen",  {28'b0, bif.bram_wen_b}, 0);
    check("rst_addr", bif.bram_addr_b, 0);
    check("rst_rv0",  {31'b0, bif.m0_rvalid}, 0);

    // preload words 0x10 and 0x20
    pre_we = 1'b1; pre_idx = 6'd4; pre_dat = 32'hDEAD_BEEF;
    tick();
    pre_idx = 6'd8; pre_dat = 32'hFFFF_FFFF;
    tick();
    pre_we = 1'b0;
    rst_n  = 1'b1;
    tick();

    // single read by M0
    req0(1, 0, 32'h10, 0, 0);
    tick();
    check("rd_ack0",  {31'b0, bif.m0_ack}, 1);
    check("rd_err0",  {31'b0, bif.m0_err}, 0);
    check("rd_en",    {31'b0, bif.bram_en_b}, 1);
    check("rd_wen",   {28'b0, bif.bram_wen_b}, 0);
    check("rd_addr",  bif.bram_addr_b, 32'h10);
    check("rd_ack1",  {31'b0, bif.m1_ack}, 0);
    req0(0, 0, 0, 0, 0);
    tick();
    check("rd_rv0",   {31'b0, bif.m0_rvalid}, 1);
    check("rd_data",  bif.m_rdata, 32'hDEAD_BEEF);
    check("rd_ack0_off", {31'b0, bif.m0_ack}, 0);

    // byte write by M1, then held Req re-used for a readback
    req1(1, 1, 32'h20, 32'h1234_5678, 4'b0011);
    tick();
    check("wr_ack1",  {31'b0, bif.m1_ack}, 1);
    check("wr_en",    {31'b0, bif.bram_en_b}, 1);
    check("wr_wen",   {28'b0, bif.bram_wen_b}, 4'b0011);
    check("wr_dout",  bif.bram_dout_b, 32'h1234_5678);
    check("wr_addr",  bif.bram_addr_b, 32'h20);
    req1(1, 0, 32'h20, 0, 0);
    tick();
    check("gap_ack1", {31'b0, bif.m1_ack}, 0);
    tick();
    check("rb_ack1",  {31'b0, bif.m1_ack}, 1);
    check("rb_wen",   {28'b0, bif.bram_wen_b}, 0);
    req1(0, 0, 0, 0, 0);
    tick();
    check("rb_rv1",   {31'b0, bif.m1_rvalid}, 1);
    check("rb_data",  bif.m_rdata, 32'hFFFF_5678);
    check("rb_rv0",   {31'b0, bif.m0_rvalid}, 0);

    // contention: both masters request continuously
    req0(1, 0, 32'h10, 0, 0);
    req1(1, 0, 32'h20, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("ct_ack0_%0d", i), {31'b0, bif.m0_ack}, (i % 2 == 0) ? 1 : 0);
      check($sformatf("ct_ack1_%0d", i), {31'b0, bif.m1_ack}, (i % 2 == 1) ? 1 : 0);
      check($sformatf("ct_en_%0d", i),   {31'b0, bif.bram_en_b}, 1);
      if (i > 0) begin
        exp_rd = ((i - 1) % 2 == 0) ? 32'hDEAD_BEEF : 32'hFFFF_5678;
        check($sformatf("ct_rv0_%0d", i), {31'b0, bif.m0_rvalid}, ((i - 1) % 2 == 0) ? 1 : 0);
        check($sformatf("ct_dat_%0d", i), bif.m_rdata, exp_rd);
      end
    end
    req0(0, 0, 0, 0, 0);
    req1(0, 0, 0, 0, 0);
    tick();
    check("ct_tail_rv1", {31'b0, bif.m1_rvalid}, 1);
    check("ct_tail_dat", bif.m_rdata, 32'hFFFF_5678);
    check("ct_tail_en",  {31'b0, bif.bram_en_b}, 0);

    // after an M0 grant, a simultaneous pair goes to M1 under round-robin
    req0(1, 0, 32'h10, 0, 0);
    tick();
    check("rr_pre_ack0", {31'b0, bif.m0_ack}, 1);
    req0(0, 0, 0, 0, 0);
    tick();
    req0(1, 0, 32'h10, 0, 0);
    req1(1, 0, 32'h20, 0, 0);
    tick();
    check("rr_first_ack1", {31'b0, bif.m1_ack}, ROUND_ROBIN ? 1 : 0);
    check("rr_first_ack0", {31'b0, bif.m0_ack}, ROUND_ROBIN ? 0 : 1);
    tick();
    check("rr_second_ack1", {31'b0, bif.m1_ack}, ROUND_ROBIN ? 0 : 1);
    req0(0, 0, 0, 0, 0);
    req1(0, 0, 0, 0, 0);
    tick();
    tick();

    // out-of-range read and window edge
    req0(1, 0, 32'h0001_0000, 0, 0);
    tick();
    check("oor_ack0", {31'b0, bif.m0_ack}, 1);
    check("oor_err0", {31'b0, bif.m0_err}, 1);
    check("oor_en",   {31'b0, bif.bram_en_b}, 0);
    req0(0, 0, 0, 0, 0);
    tick();
    check("oor_rv0",  {31'b0, bif.m0_rvalid}, 0);
    req1(1, 1, 32'hFFFF_FFF0, 32'hAAAA_AAAA, 4'hF);
    tick();
    check("oor_wr_err1", {31'b0, bif.m1_err}, 1);
    check("oor_wr_wen",  {28'b0, bif.bram_wen_b}, 0);
    req1(0, 0, 0, 0, 0);
    req0(1, 0, 32'h0000_FFFC, 0, 0);
    tick();
    check("edge_err0", {31'b0, bif.m0_err}, 0);
    check("edge_en",   {31'b0, bif.bram_en_b}, 1);
    req0(0, 0, 0, 0, 0);
    tick();

    // non-zero base: below-base addresses wrap and fail
    req_b2(1, 32'h0000_00FC);
    tick();
    check("b2_low_ack", {31'b0, bif2.m0_ack}, 1);
    check("b2_low_err", {31'b0, bif2.m0_err}, 1);
    check("b2_low_en",  {31'b0, bif2.bram_en_b}, 0);
    req_b2(0, 0);
    tick();
    req_b2(1, 32'h0000_0100);
    tick();
    check("b2_base_err",  {31'b0, bif2.m0_err}, 0);
    check("b2_base_addr", bif2.bram_addr_b, 32'h100);
    req_b2(0, 0);
    tick();
    req_b2(1, 32'h0001_0100);
    tick();
    check("b2_top_err", {31'b0, bif2.m0_err}, 1);
    req_b2(0, 0);
    tick();

    // BE=0000 write: enabled but no byte written
    req0(1, 1, 32'h10, 32'h0, 4'b0000);
    tick();
    check("be0_ack0", {31'b0, bif.m0_ack}, 1);
    check("be0_en",   {31'b0, bif.bram_en_b}, 1);
    check("be0_wen",  {28'b0, bif.bram_wen_b}, 0);
    req0(1, 0, 32'h10, 0, 0);
    tick();
    tick();
    req0(0, 0, 0, 0, 0);
    tick();
    check("be0_rv0",  {31'b0, bif.m0_rvalid}, 1);
    check("be0_data", bif.m_rdata, 32'hDEAD_BEEF);

    // reset in the issue cycle of a read
    req0(1, 0, 32'h10, 0, 0);
    tick();
    check("mr_ack0_pre", {31'b0, bif.m0_ack}, 1);
    rst_n = 1'b0;
    #1;
    check("mr_ack0", {31'b0, bif.m0_ack}, 0);
    check("mr_en",   {31'b0, bif.bram_en_b}, 0);
    check("mr_addr", bif.bram_addr_b, 0);
    req0(0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("mr_rv0_a", {31'b0, bif.m0_rvalid}, 0);
    tick();
    check("mr_rv0_b", {31'b0, bif.m0_rvalid}, 0);
    req0(1, 0, 32'h10, 0, 0);
    req1(1, 0, 32'h20, 0, 0);
    tick();
    check("mr_first_ack0", {31'b0, bif.m0_ack}, 1);
    check("mr_first_ack1", {31'b0, bif.m1_ack}, 0);
    tick();
    check("mr_second_ack1", {31'b0, bif.m1_ack}, 1);
    req0(0, 0, 0, 0, 0);
    req1(0, 0, 0, 0, 0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
